audio_frame_capture: RTL and testbench



---
 rtl/audio_pkg.sv | 15 +
 rtl/eoc_sync.sv | 38 +++
 rtl/audio_frame_capture.sv | 99 +++++++++
 tb/tb_audio_frame_capture.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared types and constants for the ADC frame-capture path.
package audio_pkg;

  localparam int SAMPLE_W      = 8;
  localparam int DEF_FRAME_LEN = 64;
  localparam int ADDR_W        = $clog2(DEF_FRAME_LEN);

  typedef logic [SAMPLE_W-1:0] sample_t;

  typedef enum logic {
    FILL,
    COMMIT
  } cap_state_t;

endpackage

// File: rtl/eoc_sync.sv
// Synchronizes the ADC eoc strobe and emits one capture pulse per rising edge.
module eoc_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic eoc,
  output logic capture
);

  logic [SYNC_STAGES-1:0] sync;
  logic [SYNC_STAGES-1:0] fill;
  logic                   prev;
  logic                   armed;
  logic                   sync_out;
  logic                   fill_done;

  assign sync_out  = sync[SYNC_STAGES-1];
  assign fill_done = fill[SYNC_STAGES-1];

  // Only arm after a genuine synchronized low, so eoc high across reset is ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync    <= '0;
      fill    <= '0;
      prev    <= 1'b0;
      armed   <= 1'b0;
      capture <= 1'b0;
    end else begin
      sync    <= {sync[SYNC_STAGES-2:0], eoc};
      fill    <= {fill[SYNC_STAGES-2:0], 1'b1};
      prev    <= sync_out;
      armed   <= armed | (fill_done & ~sync_out);
      capture <= armed & sync_out & ~prev;
    end
  end

endmodule

// File: rtl/audio_frame_capture.sv
// Packs ADC samples into ping-pong frames with valid/ack hand-off.
// ADC_SIGN_CONVERT_EN stores samples as two's complement (audio ^ 8'h80).
module audio_frame_capture
  import audio_pkg::*;
#(
  parameter int FRAME_LEN   = DEF_FRAME_LEN,
  parameter int SYNC_STAGES = 2,
  localparam int AW         = $clog2(FRAME_LEN)
) (
  input  logic          clk,
  input  logic          reset,
  input  sample_t       audio,
  input  logic          eoc,
  output logic          frame_valid,
  input  logic          frame_ack,
  input  logic [AW-1:0] rd_addr,
  output sample_t       rd_data,
  output logic          overrun,
  output logic [AW-1:0] wr_index
);

  logic          capture;
  cap_state_t    state, state_n;
  logic          bank, bank_n;
  logic          fv_n, ovr_n;
  logic [AW-1:0] idx_n;
  logic [AW:0]   waddr;
  sample_t       wdata;
  sample_t       mem [2*FRAME_LEN];

  eoc_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .reset  (reset),
    .eoc    (eoc),
    .capture(capture)
  );

`ifdef ADC_SIGN_CONVERT_EN
  assign wdata = audio ^ 8'h80;
`else
  assign wdata = audio;
`endif

  always_comb begin
    state_n = state;
    bank_n  = bank;
    idx_n   = wr_index;
    fv_n    = frame_valid & ~frame_ack;
    ovr_n   = 1'b0;
    waddr   = {bank, wr_index};
    unique case (state)
      FILL: begin
        if (capture) begin
          idx_n = wr_index + 1'b1;
          if (wr_index == AW'(FRAME_LEN-1))
            state_n = COMMIT;
        end
      end
      COMMIT: begin
        state_n = FILL;
        if (!frame_valid || frame_ack) begin
          bank_n = ~bank;
          fv_n   = 1'b1;
        end else begin
          ovr_n  = 1'b1;
        end
        // A stray capture here lands at slot 0 of the bank being filled next.
        waddr = {bank_n, {AW{1'b0}}};
        idx_n = capture ? AW'(1) : '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (capture)
      mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= FILL;
      bank        <= 1'b0;
      wr_index    <= '0;
      frame_valid <= 1'b0;
      overrun     <= 1'b0;
      rd_data     <= '0;
    end else begin
      state       <= state_n;
      bank        <= bank_n;
      wr_index    <= idx_n;
      frame_valid <= fv_n;
      overrun     <= ovr_n;
      rd_data     <= mem[{~bank, rd_addr}];
    end
  end

endmodule

// File: tb/tb_audio_frame_capture.sv
// Directed bench for audio_frame_capture: vector table plus corner sequences.
module tb_audio_frame_capture;

  localparam int FL = 64;

  typedef struct {
    logic [7:0] smp;
    logic [5:0] addr;
    logic [7:0] exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       eoc = 1'b0;
  logic       frame_ack = 1'b0;
  logic [7:0] audio = 8'h00;
  logic [5:0] rd_addr = 6'd0;
  logic       frame_valid;
  logic       overrun;
  logic [7:0] rd_data;
  logic [5:0] wr_index;

  int nvec = 0;
  int nerr = 0;
  int ovr_cnt = 0;

  logic [7:0] sine [25] = '{
    8'd128, 8'd160, 8'd189, 8'd215, 8'd236,
    8'd249, 8'd255, 8'd253, 8'd243, 8'd226,
    8'd203, 8'd175, 8'd144, 8'd112, 8'd81,
    8'd53,  8'd30,  8'd13,  8'd3,   8'd1,
    8'd7,   8'd20,  8'd41,  8'd67,  8'd96
  };

  vec_t vt [FL];

  audio_frame_capture #(
    .FRAME_LEN  (FL),
    .SYNC_STAGES(2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .audio      (audio),
    .eoc        (eoc),
    .frame_valid(frame_valid),
    .frame_ack  (frame_ack),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .overrun    (overrun),
    .wr_index   (wr_index)
  );

  always #10 clk = ~clk;

  always @(negedge clk) if (overrun === 1'b1) ovr_cnt++;

  function automatic logic [7:0] conv(input logic [7:0] a);
`ifdef ADC_SIGN_CONVERT_EN
    return a ^ 8'h80;
`else
    return a;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] a);
    @(negedge clk);
    audio = a;
    eoc = 1'b1;
    repeat (5) @(negedge clk);
    eoc = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  // Last sample of a frame: locate the COMMIT cycle and check the hand-off.
  task automatic send_last(input logic [7:0] a, input logic fv_before,
                           input logic ack_in_commit);
    bit seen;
    seen = 0;
    @(negedge clk);
    audio = a;
    eoc = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (wr_index == 6'd0) seen = 1;
    end
    check("commit_reached", 32'(seen), 32'd1);
    check("fv_before_commit", 32'(frame_valid), 32'(fv_before));
    if (ack_in_commit) frame_ack = 1'b1;
    @(posedge clk);
    #1;
    frame_ack = 1'b0;
    check("fv_after_commit", 32'(frame_valid), 32'd1);
    repeat (3) @(negedge clk);
    eoc = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic rd(input logic [5:0] a, output logic [7:0] d);
    @(negedge clk);
    rd_addr = a;
    @(posedge clk);
    #1;
    d = rd_data;
  endtask

  task automatic ack();
    @(negedge clk);
    frame_ack = 1'b1;
    @(negedge clk);
    frame_ack = 1'b0;
  endtask

  initial begin
    logic [7:0] d;
    int ovr0;

    for (int i = 0; i < FL; i++) begin
      vt[i].smp  = sine[i % 25];
      vt[i].addr = 6'(i);
      vt[i].exp  = conv(sine[i % 25]);
    end

    repeat (10) @(negedge clk);
    check("rst_frame_valid", 32'(frame_valid), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_wr_index", 32'(wr_index), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    send(8'd127);
    check("first_capture_idx", 32'(wr_index), 32'd1);
    for (int i = 1; i < FL - 1; i++) send(8'd127);
    check("idx_before_last", 32'(wr_index), 32'd63);
    send_last(8'd127, 1'b0, 1'b0);
    rd(6'd0, d);
    check("f1_idx0", 32'(d), 32'(conv(8'd127)));
    rd(6'd63, d);
    check("f1_idx63", 32'(d), 32'(conv(8'd127)));

    ack();
    check("ack_clears_valid", 32'(frame_valid), 32'd0);
    for (int i = 0; i < FL - 1; i++) send(vt[i].smp);
    send_last(vt[FL-1].smp, 1'b0, 1'b0);
    for (int i = 0; i < FL; i++) begin
      rd(vt[i].addr, d);
      check($sformatf("sine_idx%0d", i), 32'(d), 32'(vt[i].exp));
    end

    ovr0 = ovr_cnt;
    for (int i = 0; i < FL - 1; i++) send(8'h11);
    send_last(8'h11, 1'b1, 1'b0);
    check("overrun_once", 32'(ovr_cnt), 32'(ovr0 + 1));
    rd(6'd0, d);
    check("held_idx0", 32'(d), 32'(conv(sine[0])));
    rd(6'd37, d);
    check("held_idx37", 32'(d), 32'(conv(sine[12])));

    ovr0 = ovr_cnt;
    for (int i = 0; i < FL - 1; i++) send(8'h22);
    send_last(8'h23, 1'b1, 1'b1);
    check("collide_no_overrun", 32'(ovr_cnt), 32'(ovr0));
    rd(6'd0, d);
    check("collide_swapped0", 32'(d), 32'(conv(8'h22)));
    rd(6'd63, d);
    check("collide_swapped63", 32'(d), 32'(conv(8'h23)));

    @(negedge clk);
    audio = 8'h33;
    eoc = 1'b1;
    repeat (500) @(negedge clk);
    eoc = 1'b0;
    repeat (5) @(negedge clk);
    check("long_eoc_one_capture", 32'(wr_index), 32'd1);

    for (int i = 0; i < 29; i++) send(8'h40);
    check("idx_30", 32'(wr_index), 32'd30);
    @(negedge clk);
    #3 reset = 1'b1;
    #1;
    check("async_rst_idx", 32'(wr_index), 32'd0);
    check("async_rst_valid", 32'(frame_valid), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    for (int i = 0; i < FL - 1; i++) send(8'h44);
    check("post_rst_63_no_valid", 32'(frame_valid), 32'd0);
    send_last(8'h55, 1'b0, 1'b0);
    rd(6'd0, d);
    check("post_rst_idx0", 32'(d), 32'(conv(8'h44)));
    rd(6'd63, d);
    check("post_rst_idx63", 32'(d), 32'(conv(8'h55)));

    @(negedge clk);
    reset = 1'b1;
    eoc = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("eoc_high_at_release", 32'(wr_index), 32'd0);
    eoc = 1'b0;
    repeat (5) @(negedge clk);
    eoc = 1'b1;
    repeat (5) @(negedge clk);
    eoc = 1'b0;
    repeat (5) @(negedge clk);
    check("eoc_rearm_capture", 32'(wr_index), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
